// File: rtl/usr_pkg.sv
// usr_pkg: shared enums for the universal shift register (mode, FSM state, burst direction)
package usr_pkg;
  typedef enum logic [1:0] {MODE_HOLD, MODE_SHL, MODE_SHR, MODE_LOAD} mode_e;
  typedef enum logic {IDLE, BURST} state_e;
  typedef enum logic {DIR_L, DIR_R} dir_e;
endpackage

// File: rtl/univ_shift_reg_if.sv
// univ_shift_reg_if: bus bundle; master drives mode/d/sin_l/sin_r/start/count, slave returns q/qn/busy/done
interface univ_shift_reg_if #(parameter int WIDTH = 8, parameter int CNT_W = $clog2(WIDTH + 1));
  logic [1:0] mode;
  logic [WIDTH-1:0] d;
  logic sin_l;
  logic sin_r;
  logic start;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic busy;
  logic done;
  modport master(output mode, d, sin_l, sin_r, start, count, input q, qn, busy, done);
  modport slave(input mode, d, sin_l, sin_r, start, count, output q, qn, busy, done);
endinterface

// File: rtl/usr_bit_cell.sv
// usr_bit_cell: one storage bit (clk, async active-low reset, sel picks hold/from_lo/from_hi/ld, q)
module usr_bit_cell import usr_pkg::*; (
  input  logic  clk,
  input  logic  reset,
  input  mode_e sel,
  input  logic  from_lo,
  input  logic  from_hi,
  input  logic  ld,
  output logic  q
);
  logic nxt;
  always_comb nxt = sel == MODE_HOLD ? q : sel == MODE_SHL ? from_lo : sel == MODE_SHR ? from_hi : ld;
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= 1'b0;
    else q <= nxt;
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit hold/shl/shr/load register with burst sequencer (clk, async active-low reset, bus.slave)
module univ_shift_reg import usr_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic clk,
  input logic reset,
  univ_shift_reg_if.slave bus
);
  state_e state, state_nxt;
  dir_e dir;
  mode_e m, sel;
  logic [CNT_W-1:0] rem;
  logic [WIDTH-1:0] q, from_lo, from_hi;
  logic done_r, shift_req, accept, zero_req, last;
  assign m = mode_e'(bus.mode);
  assign shift_req = bus.start && (m == MODE_SHL || m == MODE_SHR);
  assign accept = state == IDLE && shift_req && bus.count != '0;
  assign zero_req = state == IDLE && shift_req && bus.count == '0;
  assign last = state == BURST && rem == CNT_W'(1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  always_comb state_nxt = accept ? BURST : last ? IDLE : state;
  always_comb begin
    sel = state == BURST ? (dir == DIR_L ? MODE_SHL : MODE_SHR) : shift_req ? MODE_HOLD : m;
    bus.busy = state == BURST;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      dir <= DIR_L;
      rem <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= zero_req || last;
      if (accept) begin
        dir <= m == MODE_SHL ? DIR_L : DIR_R;
        rem <= bus.count > CNT_W'(WIDTH) ? CNT_W'(WIDTH) : bus.count;
      end else if (state == BURST) rem <= rem - 1'b1;
    end
  assign from_lo = {q[WIDTH-2:0], bus.sin_l};
  assign from_hi = {bus.sin_r, q[WIDTH-1:1]};
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    usr_bit_cell u_cell (
      .clk(clk), .reset(reset), .sel(sel),
      .from_lo(from_lo[i]), .from_hi(from_hi[i]), .ld(bus.d[i]), .q(q[i])
    );
  end
  assign bus.q = q;
  assign bus.qn = ~q;
  assign bus.done = done_r;
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: randomized + directed scoreboard bench against an integer reference model
module tb_univ_shift_reg;
  typedef struct {logic [7:0] q; logic busy; logic done;} exp_t;
  logic clk = 0;
  logic reset = 0;
  int compared = 0;
  int mismatched = 0;
  exp_t sbq[$];
  int mq = 0;
  int mrem = 0;
  bit mbusy = 0;
  bit mdone = 0;
  bit mdir_r = 0;
  univ_shift_reg_if #(.WIDTH(8)) bus();
  univ_shift_reg #(.WIDTH(8)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic model_reset();
    mq = 0; mrem = 0; mbusy = 0; mdone = 0;
  endtask
  task automatic step(input logic [1:0] md, input logic [7:0] dd, input logic sl, input logic sr,
                      input logic st, input logic [3:0] cn);
    exp_t e;
    @(negedge clk);
    bus.mode = md; bus.d = dd; bus.sin_l = sl; bus.sin_r = sr; bus.start = st; bus.count = cn;
    @(posedge clk);
    if (mbusy) begin
      mq = mdir_r ? (mq / 2 + int'(sr) * 128) : ((mq * 2 + int'(sl)) % 256);
      mrem--;
      mbusy = mrem != 0;
      mdone = mrem == 0;
    end else begin
      mdone = 0;
      if (st && (md == 2'd1 || md == 2'd2)) begin
        if (cn == 0) mdone = 1;
        else begin
          mbusy = 1;
          mrem = cn > 8 ? 8 : int'(cn);
          mdir_r = md == 2'd2;
        end
      end else if (md == 2'd1) mq = (mq * 2 + int'(sl)) % 256;
      else if (md == 2'd2) mq = mq / 2 + int'(sr) * 128;
      else if (md == 2'd3) mq = int'(dd);
    end
    e.q = 8'(mq); e.busy = mbusy; e.done = mdone;
    sbq.push_back(e);
  endtask
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("q", bus.q, e.q);
      chk("qn", bus.qn, ~e.q);
      chk("busy", {7'd0, bus.busy}, {7'd0, e.busy});
      chk("done", {7'd0, bus.done}, {7'd0, e.done});
      chk("busy_done_excl", {7'd0, bus.busy & bus.done}, 8'd0);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.mode = 0; bus.d = 0; bus.sin_l = 0; bus.sin_r = 0; bus.start = 0; bus.count = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_q", bus.q, 8'h00);
    chk("reset_qn", bus.qn, 8'hFF);
    @(negedge clk);
    reset = 1;
    step(2'd3, 8'h3C, 0, 0, 0, 0);
    #3 reset = 0;
    model_reset();
    #1;
    chk("async_rst_q", bus.q, 8'h00);
    chk("async_rst_qn", bus.qn, 8'hFF);
    chk("async_rst_busy", {7'd0, bus.busy}, 8'd0);
    @(negedge clk);
    reset = 1;
    step(2'd3, 8'hA5, 0, 0, 0, 0);
    #2 chk("load_a5", bus.q, 8'hA5);
    step(2'd1, 8'h00, 1, 0, 0, 0);
    #2 chk("shl_4b", bus.q, 8'h4B);
    step(2'd2, 8'h00, 0, 0, 0, 0);
    #2 chk("shr_25", bus.q, 8'h25);
    step(2'd3, 8'h81, 0, 0, 0, 0);
    step(2'd1, 8'h00, 0, 0, 1, 4'd3);
    #2 chk("accept_hold", bus.q, 8'h81);
    for (int i = 0; i < 3; i++) step(2'($urandom_range(0, 3)), 8'($urandom), 0, 1'($urandom), 1'($urandom), 4'($urandom));
    #2 chk("burst3_q", bus.q, 8'h08);
    chk("burst3_done", {7'd0, bus.done}, 8'd1);
    step(2'd0, 8'h00, 0, 0, 0, 0);
    #2 chk("burst3_done_fall", {7'd0, bus.done}, 8'd0);
    step(2'd2, 8'h00, 0, 1, 1, 4'd0);
    #2 chk("cnt0_q", bus.q, 8'h08);
    chk("cnt0_done", {7'd0, bus.done}, 8'd1);
    step(2'd3, 8'hFF, 0, 0, 0, 0);
    step(2'd1, 8'h00, 0, 0, 1, 4'd12);
    for (int i = 0; i < 8; i++) step(2'd3, 8'hFF, 0, 1, 1, 4'd5);
    #2 chk("sat_q", bus.q, 8'h00);
    chk("sat_done", {7'd0, bus.done}, 8'd1);
    step(2'd3, 8'hC3, 0, 0, 0, 0);
    step(2'd1, 8'h00, 1, 0, 1, 4'd5);
    step(2'd0, 8'h00, 1, 0, 0, 0);
    step(2'd0, 8'h00, 1, 0, 0, 0);
    #3 reset = 0;
    model_reset();
    #1;
    chk("midburst_rst_q", bus.q, 8'h00);
    chk("midburst_rst_busy", {7'd0, bus.busy}, 8'd0);
    repeat (4) @(posedge clk);
    #1 chk("midburst_no_done", {7'd0, bus.done}, 8'd0);
    @(negedge clk);
    reset = 1;
    step(2'd3, 8'h5A, 0, 0, 0, 0);
    #2 chk("post_rst_load", bus.q, 8'h5A);
    for (int i = 0; i < 400; i++)
      step(2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)));
    repeat (3) @(posedge clk);
    #2;
    compared++;
    if (sbq.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
